rps_punch_capture: RTL and testbench

Input-side front end for the two-player rock-paper-scissors game: debounces raw player push-buttons and a round-start button, runs the round sequencing, and produces the 4-bit one-hot punch codes `punch_1`/`punch_2` consumed by the matrix / seven-segment display logic. Choices stay hidden (code 0000) until both players have committed or the round times out, then both are revealed in the same cycle and held until the next round.

---
 rtl/rps_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/rps_punch_capture.sv | 143 ++++++++++++++
 tb/tb_rps_punch_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared punch codes and phase encoding for the rock-paper-scissors datapath.
package rps_pkg;

   localparam logic [3:0] PUNCH_NONE     = 4'b0000;
   localparam logic [3:0] PUNCH_SCISSORS = 4'b0001;
   localparam logic [3:0] PUNCH_STONE    = 4'b0010;
   localparam logic [3:0] PUNCH_PAPER    = 4'b0100;
   localparam logic [3:0] PUNCH_FOUL     = 4'b1000;

   typedef enum logic [1:0] {
      PH_IDLE    = 2'b00,
      PH_COLLECT = 2'b01,
      PH_REVEAL  = 2'b10
   } phase_e;

   // Button vector {paper, stone, scissors} to punch code; multiple presses are a foul.
   function automatic logic [3:0] encode_punch(input logic [2:0] vec);
      logic [3:0] code;
      case (vec)
         3'b000:  code = PUNCH_NONE;
         3'b001:  code = PUNCH_SCISSORS;
         3'b010:  code = PUNCH_STONE;
         3'b100:  code = PUNCH_PAPER;
         default: code = PUNCH_FOUL;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic deb_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronizer, debounced value and stable counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
         deb_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   // Count cycles the synchronized value differs from the debounced one; any agreement restarts.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/rps_punch_capture.sv
// Round sequencing front end: debounces buttons, collects both punches hidden, reveals together.
module rps_punch_capture
   import rps_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
   input  logic       CLK,
   input  logic       Clear,
   input  logic [2:0] btn_1,
   input  logic [2:0] btn_2,
   input  logic       start,
   output logic [3:0] punch_1,
   output logic [3:0] punch_2,
   output logic [1:0] phase,
   output logic       reveal_pulse
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [6:0]      raw_vec, deb_vec;
   logic [1:0][2:0] btn_deb;
   logic            start_deb, start_prev_q, start_rise;

   phase_e          state_q, state_d;
   logic            enter_collect, to_reveal;

   logic [1:0]      arm_q, arm_d;
   logic [1:0]      lock_q, lock_d;
   logic [1:0][3:0] code_q, code_d;
   logic [TW-1:0]   tmo_q, tmo_d;

   logic [1:0][3:0] punch_q, punch_d;
   logic            pulse_q, pulse_d;

   assign raw_vec = {start, btn_2, btn_1};

   for (genvar g = 0; g < 7; g++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i (CLK),
         .rst_ni(Clear),
         .raw_i (raw_vec[g]),
         .deb_o (deb_vec[g])
      );
   end

   assign btn_deb[0] = deb_vec[2:0];
   assign btn_deb[1] = deb_vec[5:3];
   assign start_deb  = deb_vec[6];
   assign start_rise = start_deb & ~start_prev_q;

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (!Clear) begin
         state_q <= PH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start edges are only honoured outside COLLECT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         PH_IDLE:    if (start_rise) state_d = PH_COLLECT;
         PH_COLLECT: if ((&lock_q) || (tmo_q == TMO_LAST)) state_d = PH_REVEAL;
         PH_REVEAL:  if (start_rise) state_d = PH_COLLECT;
         default:    state_d = PH_IDLE;
      endcase
   end

   assign enter_collect = (state_q != PH_COLLECT) && (state_d == PH_COLLECT);
   assign to_reveal     = (state_q == PH_COLLECT) && (state_d == PH_REVEAL);

   // Arm/lock/code/timeout update; a lock taken on the timeout cycle still feeds the reveal.
   always_comb begin
      arm_d  = arm_q;
      lock_d = lock_q;
      code_d = code_q;
      tmo_d  = tmo_q;
      if (state_q == PH_COLLECT) begin
         if (tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
         for (int unsigned p = 0; p < 2; p++) begin
            if (btn_deb[p] == 3'b000) begin
               arm_d[p] = 1'b1;
            end else if (arm_q[p] && !lock_q[p]) begin
               lock_d[p] = 1'b1;
               code_d[p] = encode_punch(btn_deb[p]);
            end
         end
      end
      if (enter_collect) begin
         arm_d  = '0;
         lock_d = '0;
         code_d = '0;
         tmo_d  = '0;
      end
   end

   // FSM outputs: reveal loads latched codes (foul for no-show), otherwise hidden unless in REVEAL.
   always_comb begin
      punch_d = punch_q;
      pulse_d = 1'b0;
      if (to_reveal) begin
         pulse_d = 1'b1;
         for (int unsigned p = 0; p < 2; p++) begin
            punch_d[p] = lock_d[p] ? code_d[p] : PUNCH_FOUL;
         end
      end else if (state_d != PH_REVEAL) begin
         punch_d = '0;
      end
   end

   // Datapath and registered output state.
   always_ff @(posedge CLK) begin
      if (!Clear) begin
         start_prev_q <= 1'b0;
         arm_q        <= '0;
         lock_q       <= '0;
         code_q       <= '0;
         tmo_q        <= '0;
         punch_q      <= '0;
         pulse_q      <= 1'b0;
      end else begin
         start_prev_q <= start_deb;
         arm_q        <= arm_d;
         lock_q       <= lock_d;
         code_q       <= code_d;
         tmo_q        <= tmo_d;
         punch_q      <= punch_d;
         pulse_q      <= pulse_d;
      end
   end

   assign punch_1      = punch_q[0];
   assign punch_2      = punch_q[1];
   assign phase        = state_q;
   assign reveal_pulse = pulse_q;

endmodule

// File: tb/tb_rps_punch_capture.sv
// Scoreboard bench for rps_punch_capture with short debounce and timeout settings.
module tb_rps_punch_capture;

   logic       CLK = 1'b0;
   logic       Clear = 1'b0;
   logic [2:0] btn_1 = 3'b000;
   logic [2:0] btn_2 = 3'b000;
   logic       start = 1'b0;
   logic [3:0] punch_1, punch_2;
   logic [1:0] phase;
   logic       reveal_pulse;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   logic prev_pulse = 1'b0;

   typedef struct {
      logic [3:0] p1;
      logic [3:0] p2;
      int         due;
      string      name;
   } exp_t;

   exp_t sb[$];

   rps_punch_capture #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .CLK         (CLK),
      .Clear       (Clear),
      .btn_1       (btn_1),
      .btn_2       (btn_2),
      .start       (start),
      .punch_1     (punch_1),
      .punch_2     (punch_2),
      .phase       (phase),
      .reveal_pulse(reveal_pulse)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_phase(input logic [1:0] ph, input int maxc, input string name, output int at);
      int n;
      n = 0;
      while (phase !== ph && n < maxc) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (phase !== ph) begin
         errors++;
         $display("FAIL %s: phase %b required %b within %0d cycles", name, phase, ph, maxc);
      end
      at = cyc;
   endtask

   // Monitor: pops one expectation per reveal strobe; punches must be hidden outside REVEAL.
   always @(negedge CLK) begin
      exp_t e;
      if (mon_en && Clear) begin
         if (reveal_pulse) begin
            chk("pulse_single", {31'd0, prev_pulse}, 32'd0);
            chk("reveal_phase", {30'd0, phase}, 32'd2);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_reveal: got p1=%b p2=%b required no reveal", punch_1, punch_2);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_p1"}, {28'd0, punch_1}, {28'd0, e.p1});
               chk({e.name, "_p2"}, {28'd0, punch_2}, {28'd0, e.p2});
               if (e.due >= 0) chk({e.name, "_cycle"}, cyc, e.due);
            end
         end
         if (phase != 2'b10) begin
            chk("hidden_p1", {28'd0, punch_1}, 32'd0);
            chk("hidden_p2", {28'd0, punch_2}, 32'd0);
         end
      end
      prev_pulse = reveal_pulse;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int e_at, c, t;
      exp_t x;

      // Reset state
      tick(3);
      chk("rst_phase", {30'd0, phase}, 32'd0);
      chk("rst_p1", {28'd0, punch_1}, 32'd0);
      chk("rst_p2", {28'd0, punch_2}, 32'd0);
      chk("rst_pulse", {31'd0, reveal_pulse}, 32'd0);
      Clear = 1'b1;
      mon_en = 1'b1;
      tick(2);

      // Normal round: stone vs paper, reveal one cycle after the second lock
      start = 1'b1;
      wait_phase(2'b01, 20, "s1_enter", e_at);
      start = 1'b0;
      tick(3);
      btn_1 = 3'b010;
      tick(20);
      c = cyc;
      btn_2 = 3'b100;
      x = '{4'b0010, 4'b0100, c + 8, "s1_normal"};
      sb.push_back(x);
      wait_phase(2'b10, 40, "s1_reveal", t);
      tick(2);
      btn_1 = 3'b000;
      btn_2 = 3'b000;
      tick(10);
      chk("s1_hold_p1", {28'd0, punch_1}, 32'h2);
      chk("s1_hold_p2", {28'd0, punch_2}, 32'h4);

      // Bounce rejection on scissors
      start = 1'b1;
      wait_phase(2'b01, 20, "s2_enter", e_at);
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         btn_1 = (i % 2 == 0) ? 3'b001 : 3'b000;
         tick(2);
      end
      btn_1 = 3'b001;
      tick(12);
      btn_2 = 3'b010;
      x = '{4'b0001, 4'b0010, -1, "s2_bounce"};
      sb.push_back(x);
      wait_phase(2'b10, 40, "s2_reveal", t);
      btn_1 = 3'b000;
      btn_2 = 3'b000;
      tick(10);

      // Foul and timeout: reveal exactly 100 cycles after entry
      start = 1'b1;
      wait_phase(2'b01, 20, "s3_enter", e_at);
      x = '{4'b1000, 4'b1000, e_at + 100, "s3_timeout"};
      sb.push_back(x);
      start = 1'b0;
      tick(3);
      btn_1 = 3'b101;
      wait_phase(2'b10, 120, "s3_reveal", t);
      btn_1 = 3'b000;
      tick(10);

      // Held-button guard: stone held across start must not count
      btn_2 = 3'b010;
      tick(8);
      start = 1'b1;
      wait_phase(2'b01, 20, "s4_enter", e_at);
      start = 1'b0;
      tick(3);
      btn_2 = 3'b000;
      tick(10);
      btn_1 = 3'b001;
      tick(2);
      btn_2 = 3'b100;
      x = '{4'b0001, 4'b0100, -1, "s4_held"};
      sb.push_back(x);
      wait_phase(2'b10, 40, "s4_reveal", t);
      btn_1 = 3'b000;
      btn_2 = 3'b000;
      tick(10);

      // Restart from REVEAL, start ignored in COLLECT, then reset mid-round
      start = 1'b1;
      wait_phase(2'b01, 20, "s5_restart", e_at);
      chk("s5_restart_p1", {28'd0, punch_1}, 32'd0);
      chk("s5_restart_p2", {28'd0, punch_2}, 32'd0);
      start = 1'b0;
      tick(4);
      start = 1'b1;
      tick(8);
      start = 1'b0;
      tick(12);
      chk("s5_ignore_phase", {30'd0, phase}, 32'd1);
      btn_1 = 3'b010;
      tick(3);
      btn_2 = 3'b001;
      x = '{4'b0010, 4'b0001, -1, "s5_round"};
      sb.push_back(x);
      wait_phase(2'b10, 40, "s5_reveal", t);
      btn_1 = 3'b000;
      btn_2 = 3'b000;
      tick(10);
      start = 1'b1;
      wait_phase(2'b01, 20, "s5_start_reveal", e_at);
      chk("s5_again_p1", {28'd0, punch_1}, 32'd0);
      chk("s5_again_p2", {28'd0, punch_2}, 32'd0);
      start = 1'b0;
      tick(5);
      Clear = 1'b0;
      tick(1);
      chk("s5_rst_phase", {30'd0, phase}, 32'd0);
      chk("s5_rst_p1", {28'd0, punch_1}, 32'd0);
      chk("s5_rst_pulse", {31'd0, reveal_pulse}, 32'd0);
      Clear = 1'b1;
      btn_1 = 3'b100;
      btn_2 = 3'b100;
      tick(20);
      chk("s5_abandon_phase", {30'd0, phase}, 32'd0);
      btn_1 = 3'b000;
      btn_2 = 3'b000;
      tick(10);

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
